// File: rtl/key_capture_pkg.sv
// key_capture shared definitions.
// Board defaults and counter sizing helper.
package key_capture_pkg;

  localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
  localparam int N_KEYS_EBAZ = 2;

  // Bits needed to hold 0..cyc.
  function automatic int cnt_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: polarity fix, 2-flop sync,
// stability counter and accepted-level edges.
module key_debounce_ch
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_20MS_50MHZ,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYC - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Normalise to pressed=1, then synchronise.
  always_comb begin
    sync1_d = key_pin ^ INV;
    sync2_d = sync1_q;
  end

  // Accept a new level after enough stable cycles.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Edges come from the next level so the
  // flags land on the same edge as lvl.
  assign lvl  = lvl_q;
  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

endmodule

// File: rtl/key_capture.sv
// Debounced key capture with sticky press/release
// flags, edge-triggered clear and summary irq.
module key_capture
  import key_capture_pkg::*;
#(
  parameter int N_KEYS       = N_KEYS_EBAZ,
  parameter int DEBOUNCE_CYC = DEBOUNCE_20MS_50MHZ,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_pin,
  input  logic [N_KEYS-1:0] evt_clr,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] evt_press,
  output logic [N_KEYS-1:0] evt_release,
  output logic              irq
);

  logic [N_KEYS-1:0] rise, fall;
  logic [N_KEYS-1:0] clr_edge;
  logic [N_KEYS-1:0] evt_clr_q, evt_clr_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic              irq_q, irq_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key_pin (key_pin[i]),
      .lvl     (key_level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // Sticky flags; a new event beats a clear.
  always_comb begin
    evt_clr_d = evt_clr;
    clr_edge  = evt_clr & ~evt_clr_q;
    press_d   = rise | (press_q & ~clr_edge);
    release_d = fall | (release_q & ~clr_edge);
    irq_d     = |{press_d, release_d};
  end

  // Flag and irq registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_clr_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      evt_clr_q <= evt_clr_d;
      press_q   <= press_d;
      release_q <= release_d;
      irq_q     <= irq_d;
    end
  end

  assign evt_press   = press_q;
  assign evt_release = release_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_key_capture.sv
// key_capture bench: directed vector table, corner
// sequences and random traffic vs a window model.
module tb_key_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_pin = 2'b11;
  logic [1:0] evt_clr = 2'b00;
  logic [1:0] key_level, evt_press, evt_release;
  logic       irq;

  int ntests = 0;
  int nfail  = 0;

  key_capture #(
    .N_KEYS       (2),
    .DEBOUNCE_CYC (D),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pin     (key_pin),
    .evt_clr     (evt_clr),
    .key_level   (key_level),
    .evt_press   (evt_press),
    .evt_release (evt_release),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Model: h[c][0] is the newest pressed-sample,
  // h[c][j] is j edges older. A level flips once
  // the D synchronised samples all disagree with it.
  bit         h [2][D+1];
  bit   [1:0] m_lvl, m_pr, m_rl, m_clrq;
  bit         m_irq;

  task automatic model_step();
    bit all_diff, p, ce, rs, fl;
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j <= D; j++) h[c][j] = 1'b0;
      m_lvl = '0; m_pr = '0; m_rl = '0;
      m_clrq = '0; m_irq = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (h[c][j] == m_lvl[c]) all_diff = 1'b0;
        rs = all_diff && !m_lvl[c];
        fl = all_diff && m_lvl[c];
        if (all_diff) m_lvl[c] = !m_lvl[c];
        p = !key_pin[c];
        for (int j = D; j >= 1; j--) h[c][j] = h[c][j-1];
        h[c][0] = p;
        ce = evt_clr[c] && !m_clrq[c];
        m_pr[c] = rs || (m_pr[c] && !ce);
        m_rl[c] = fl || (m_rl[c] && !ce);
      end
      m_clrq = evt_clr;
      m_irq = |{m_pr, m_rl};
    end
  endtask

  task automatic check(input string nm,
                       input logic [1:0] act,
                       input logic [1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // One clock: model follows the edge, then all
  // outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("mdl_level", key_level, m_lvl);
    check("mdl_press", evt_press, m_pr);
    check("mdl_release", evt_release, m_rl);
    check("mdl_irq", {1'b0, irq}, {1'b0, m_irq});
  endtask

  task automatic step(input logic r,
                      input logic [1:0] p,
                      input logic [1:0] c);
    rst = r; key_pin = p; evt_clr = c;
    tick();
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] pin;
    logic [1:0] clr;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, logic r,
    logic [1:0] p, logic [1:0] c, logic [1:0] l,
    logic [1:0] pr, logic [1:0] rl, logic q);
    vec_t v;
    v = '{r, p, c, l, pr, rl, q};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    // Reset with keys held released, then idle.
    add(10, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(3,  0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // Key 0 pressed: appears on the 6th edge.
    add(5,  0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    add(3,  0, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 1);
    // Held clear acts once, on its first edge.
    add(5,  0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    add(2,  0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 0);

    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].pin, tbl[i].clr);
      check("tv_level", key_level, tbl[i].lvl);
      check("tv_press", evt_press, tbl[i].pr);
      check("tv_release", evt_release, tbl[i].rl);
      check("tv_irq", {1'b0, irq}, {1'b0, tbl[i].irq});
    end

    // Bounce on key 1: 3-cycle runs never land.
    for (int b = 0; b < 12; b++) begin
      step(0, {((b / 3) % 2 == 1), 1'b0}, 2'b00);
      check("bnc_level1", {1'b0, key_level[1]}, 2'b00);
      check("bnc_press1", {1'b0, evt_press[1]}, 2'b00);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 2'b00, 2'b00);
      check("bnc_hold_press1", {1'b0, evt_press[1]},
            {1'b0, i >= 6});
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 2'b10, 2'b00);
      check("rel_key1", {1'b0, evt_release[1]},
            {1'b0, i == 6});
    end
    step(0, 2'b10, 2'b10);
    check("clr1_flags", {evt_press[1], evt_release[1]},
          2'b00);
    check("clr1_irq", {1'b0, irq}, 2'b00);
    step(0, 2'b10, 2'b00);

    // Release key 0, keep its flag for the collision.
    for (int i = 0; i < 6; i++) step(0, 2'b11, 2'b00);
    check("rel_key0", evt_release, 2'b01);
    // Press again with a clear edge on the rise edge.
    for (int i = 1; i <= 5; i++) step(0, 2'b10, 2'b00);
    check("pre_rise_press0", evt_press, 2'b00);
    step(0, 2'b10, 2'b01);
    check("coll_press0", evt_press, 2'b01);
    check("coll_release0", evt_release, 2'b00);
    check("coll_irq", {1'b0, irq}, 2'b01);
    step(0, 2'b10, 2'b01);
    check("coll_hold_press0", evt_press, 2'b01);
    step(0, 2'b10, 2'b00);
    step(0, 2'b10, 2'b01);
    step(0, 2'b10, 2'b00);

    // Reset mid-window, key kept held across it.
    for (int i = 0; i < 6; i++) step(0, 2'b11, 2'b00);
    step(0, 2'b11, 2'b01);
    step(0, 2'b11, 2'b00);
    check("pre_rst_flags", {evt_press | evt_release},
          2'b00);
    for (int i = 0; i < 4; i++) step(0, 2'b10, 2'b00);
    check("mid_level0", key_level, 2'b00);
    step(1, 2'b10, 2'b00);
    step(1, 2'b10, 2'b00);
    check("rst_level", key_level, 2'b00);
    check("rst_flags", {evt_press | evt_release}, 2'b00);
    check("rst_irq", {1'b0, irq}, 2'b00);
    for (int i = 1; i <= 6; i++) begin
      step(0, 2'b10, 2'b00);
      check("post_rst_press0", evt_press,
            {1'b0, i == 6});
    end

    // Random traffic, model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] p, c;
      logic r;
      p = key_pin;
      c = evt_clr;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 7) == 0) p[k] = ~p[k];
        if ($urandom_range(0, 3) == 0) c[k] = ~c[k];
      end
      r = ($urandom_range(0, 149) == 0);
      step(r, p, c);
    end

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
